pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 37 +++
 rtl/sync_ff2.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 129 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and 27 MHz defaults for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int unsigned PLL_RST_CYCLES_DEF       = 27;
    localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF  = 27000;
    localparam int unsigned LOCK_STABLE_CYCLES_DEF   = 2700;
    localparam int unsigned MAX_RETRIES_DEF          = 3;
    localparam int unsigned FAULT_BACKOFF_CYCLES_DEF = 270000;

    function automatic int unsigned umax(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // {pll_reset, sys_rst_n, locked_stable, fault} seen while in state s
    function automatic logic [3:0] state_outs(pll_state_e s);
        logic [3:0] o;
        o = 4'b1000;
        case (s)
            RESET:     o = 4'b1000;
            WAIT_LOCK: o = 4'b0000;
            STABLE:    o = 4'b0000;
            RUN:       o = 4'b0110;
            FAULT:     o = 4'b1001;
            default:   o = 4'b1000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer, async active-low reset to 0.
module sync_ff2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer driving the system reset from the reference clock.
// Define PLL_SUP_FAULT_RETRY_EN to auto-restart from FAULT after a backoff.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES       = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = LOCK_TIMEOUT_CYCLES_DEF,
    parameter int unsigned LOCK_STABLE_CYCLES   = LOCK_STABLE_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES          = MAX_RETRIES_DEF,
    parameter int unsigned FAULT_BACKOFF_CYCLES = FAULT_BACKOFF_CYCLES_DEF
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked_stable,
    output logic       fault,
    output logic [1:0] retry_count
);

    localparam int unsigned MAX_CYC = umax(umax(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                           umax(LOCK_STABLE_CYCLES, FAULT_BACKOFF_CYCLES));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SUP_FAULT_RETRY_EN
    localparam logic [CNT_W-1:0] BOFF_LAST = CNT_W'(FAULT_BACKOFF_CYCLES - 1);
`endif

    pll_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;

    sync_ff2 u_lock_sync (
        .clk   (clkin),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RESET;
            cnt           <= '0;
            retry_count   <= '0;
            pll_reset     <= 1'b1;
            sys_rst_n     <= 1'b0;
            locked_stable <= 1'b0;
            fault         <= 1'b0;
        end else begin
            unique case (state)
                RESET: begin
                    if (cnt == RST_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(WAIT_LOCK);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // lock has priority over a coincident timeout
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                        {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(STABLE);
                    end else if (cnt == TMO_LAST) begin
                        cnt <= '0;
                        if (32'(retry_count) < MAX_RETRIES) begin
                            state       <= RESET;
                            retry_count <= (retry_count == 2'd3) ? 2'd3 : retry_count + 2'd1;
                            {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(RESET);
                        end else begin
                            state <= FAULT;
                            {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(FAULT);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(WAIT_LOCK);
                    end else if (cnt == STB_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(RUN);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state       <= RESET;
                        cnt         <= '0;
                        retry_count <= '0;
                        {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(RESET);
                    end
                end
                FAULT: begin
`ifdef PLL_SUP_FAULT_RETRY_EN
                    if (cnt == BOFF_LAST) begin
                        state       <= RESET;
                        cnt         <= '0;
                        retry_count <= '0;
                        {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(RESET);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    cnt <= cnt;
`endif
                end
                default: begin
                    state       <= RESET;
                    cnt         <= '0;
                    retry_count <= '0;
                    {pll_reset, sys_rst_n, locked_stable, fault} <= state_outs(RESET);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with shortened cycle parameters.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked_stable;
    logic       fault;
    logic [1:0] retry_count;

    typedef struct {
        int         scen;
        int         cyc;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        int r1;
        int f1;
        int r2;
        int n;
        int rises;
        int falls;
    } scen_t;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    vec_t  vecs[$];
    scen_t scens[5];
    sb_t   sb[$];
    int    total = 0;
    int    bad = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES       (4),
        .LOCK_TIMEOUT_CYCLES  (20),
        .LOCK_STABLE_CYCLES   (8),
        .MAX_RETRIES          (2),
        .FAULT_BACKOFF_CYCLES (16)
    ) dut (
        .clkin         (clkin),
        .reset_n       (reset_n),
        .pll_lock      (pll_lock),
        .pll_reset     (pll_reset),
        .sys_rst_n     (sys_rst_n),
        .locked_stable (locked_stable),
        .fault         (fault),
        .retry_count   (retry_count)
    );

    always #5 clkin = ~clkin;

    // {pll_reset, sys_rst_n, locked_stable, fault, retry_count}
    function automatic logic [5:0] outs();
        return {pll_reset, sys_rst_n, locked_stable, fault, retry_count};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic add(input int s, input int c, input logic [5:0] e);
        vec_t v;
        v.scen = s;
        v.cyc  = c;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // leaves time just after edge E0, the last edge seen with reset_n low
    task automatic do_reset(input int s);
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        check($sformatf("s%0d_in_reset", s), outs(), 6'b100000);
        @(posedge clkin);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_scen(input int s);
        int   rises;
        int   falls;
        logic prev;
        sb_t  e;
        rises = 0;
        falls = 0;
        prev  = 1'b1;
        do_reset(s);
        for (int k = 0; k <= scens[s].n; k++) begin
            pll_lock = ((k >= scens[s].r1) && (k < scens[s].f1)) || (k >= scens[s].r2);
            foreach (vecs[i]) begin
                if (vecs[i].scen == s && vecs[i].cyc == k) begin
                    e.name = $sformatf("s%0d_c%0d", s, k);
                    e.exp  = vecs[i].exp;
                    sb.push_back(e);
                end
            end
            @(negedge clkin);
            if (k > 0) begin
                if (!prev && pll_reset) rises++;
                if (prev && !pll_reset) falls++;
            end
            prev = pll_reset;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, outs(), e.exp);
            end
            @(posedge clkin);
            #1;
        end
        check_int($sformatf("s%0d_rises", s), rises, scens[s].rises);
        check_int($sformatf("s%0d_falls", s), falls, scens[s].falls);
    endtask

    initial begin
        // nominal lock
        scens[0] = '{r1: 7, f1: 9999, r2: 9999, n: 20, rises: 0, falls: 1};
        add(0, 0,  6'b100000);
        add(0, 3,  6'b100000);
        add(0, 4,  6'b000000);
        add(0, 17, 6'b000000);
        add(0, 18, 6'b011000);
        add(0, 20, 6'b011000);
        // one retry then lock
        scens[1] = '{r1: 33, f1: 9999, r2: 9999, n: 46, rises: 1, falls: 2};
        add(1, 23, 6'b000000);
        add(1, 24, 6'b100001);
        add(1, 27, 6'b100001);
        add(1, 28, 6'b000001);
        add(1, 43, 6'b000001);
        add(1, 44, 6'b011001);
        // never locks
`ifdef PLL_SUP_FAULT_RETRY_EN
        scens[2] = '{r1: 9999, f1: 9999, r2: 9999, n: 92, rises: 3, falls: 4};
`else
        scens[2] = '{r1: 9999, f1: 9999, r2: 9999, n: 92, rises: 3, falls: 3};
`endif
        add(2, 51, 6'b100010);
        add(2, 52, 6'b000010);
        add(2, 71, 6'b000010);
        add(2, 72, 6'b100110);
        add(2, 87, 6'b100110);
`ifdef PLL_SUP_FAULT_RETRY_EN
        add(2, 88, 6'b100000);
        add(2, 91, 6'b100000);
        add(2, 92, 6'b000000);
`else
        add(2, 88, 6'b100110);
        add(2, 92, 6'b100110);
`endif
        // 3-cycle lock glitch after 5 stable cycles
        scens[3] = '{r1: 7, f1: 12, r2: 15, n: 27, rises: 0, falls: 1};
        add(3, 14, 6'b000000);
        add(3, 15, 6'b000000);
        add(3, 25, 6'b000000);
        add(3, 26, 6'b011000);
        // lock lost in RUN
        scens[4] = '{r1: 7, f1: 20, r2: 9999, n: 28, rises: 1, falls: 2};
        add(4, 22, 6'b011000);
        add(4, 23, 6'b100000);
        add(4, 26, 6'b100000);
        add(4, 27, 6'b000000);

        for (int s = 0; s < 5; s++) run_scen(s);

        // async reset in the second WAIT_LOCK at count 10
        do_reset(5);
        for (int k = 0; k < 38; k++) @(posedge clkin);
        #1;
        check("async_pre", outs(), 6'b000001);
        reset_n = 1'b0;
        #1;
        check("async_now", outs(), 6'b100000);
        #10;
        check("async_hold", outs(), 6'b100000);
        @(posedge clkin);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clkin);
        @(negedge clkin);
        check("async_rst_c3", outs(), 6'b100000);
        @(negedge clkin);
        check("async_rst_c4", outs(), 6'b000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
